// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard, redirect and forwarding control for the 5-stage pipeline,
//            including issue hold for the multi-cycle mul/div unit.
//            Optional macro BRANCH_FLUSH_EN: flush IF/ID on a taken redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_branch_taken,
    input  logic       id_jump,
    input  logic       id_is_md,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_rn,
    output logic       stall,
    output logic [1:0] pcsource,
    output logic       flush_ifid,
    output logic       bubble_idex,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_start,
    output logic       md_busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] C_CNT_LOAD = 4'(MD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic       load_use;
    logic       busy;
    logic       stall_raw;
    logic       md_start_raw;
    logic [1:0] pcsource_raw;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // Register 0 is hardwired, so it never participates in any match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic       exw,
        input logic       exm,
        input logic [4:0] exrn,
        input logic       memw,
        input logic       memm,
        input logic [4:0] memrn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != 5'd0)) begin
            if (exw && !exm && (exrn == src)) begin
                sel = 2'b01;
            end else if (memw && !memm && (memrn == src)) begin
                sel = 2'b10;
            end else if (memw && memm && (memrn == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
                   ((id_use_rs && (id_rs == ex_rn)) ||
                    (id_use_rt && (id_rt == ex_rn)));
        busy         = (state_q == BUSY);
        stall_raw    = load_use || busy;
        md_start_raw = !busy && !load_use && id_is_md;

        pcsource_raw = 2'b00;
        if (!stall_raw) begin
            if (id_jump) begin
                pcsource_raw = 2'b10;
            end else if (id_branch_taken) begin
                pcsource_raw = 2'b01;
            end
        end

        fwd_a_raw = fwd_sel(id_rs, id_use_rs, ex_wreg, ex_m2reg, ex_rn,
                            mem_wreg, mem_m2reg, mem_rn);
        fwd_b_raw = fwd_sel(id_rt, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
                            mem_wreg, mem_m2reg, mem_rn);
    end

    // Outputs are gated by clrn so they read zero for the whole reset window.
    always_comb begin
        stall       = clrn && stall_raw;
        bubble_idex = clrn && stall_raw;
        md_start    = clrn && md_start_raw;
        md_busy     = clrn && busy;
        pcsource    = clrn ? pcsource_raw : 2'b00;
        fwd_a       = clrn ? fwd_a_raw : 2'b00;
        fwd_b       = clrn ? fwd_b_raw : 2'b00;
`ifdef BRANCH_FLUSH_EN
        flush_ifid  = clrn && !stall_raw && (pcsource_raw != 2'b00);
`else
        flush_ifid  = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start_raw) begin
                    state_d = BUSY;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed and randomized bench for pipe_hazard_ctrl against a
//            rule-level reference model (honours BRANCH_FLUSH_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       clrn;
    logic [4:0] id_rs, id_rt, ex_rn, mem_rn;
    logic       id_use_rs, id_use_rt, id_branch_taken, id_jump, id_is_md;
    logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic       stall, flush_ifid, bubble_idex, md_start, md_busy;
    logic [1:0] pcsource, fwd_a, fwd_b;

    int errors = 0;
    int checks = 0;
    int hold   = 0;     // remaining issue-hold cycles of the mul/div unit
    bit exp_mds;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_is_md(id_is_md),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .stall(stall), .pcsource(pcsource), .flush_ifid(flush_ifid),
        .bubble_idex(bubble_idex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic used);
        if (!used || src == 0)                         return 2'd0;
        if (ex_wreg && !ex_m2reg && ex_rn == src)      return 2'd1;
        if (mem_wreg && mem_rn == src)                 return mem_m2reg ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic model_check();
        bit lu, busy, st, fl;
        logic [1:0] pcs;
        lu   = ex_wreg && ex_m2reg && ex_rn != 0 &&
               ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));
        busy = (hold > 0);
        st   = clrn && (lu || busy);
        pcs  = (!clrn || st) ? 2'd0 : id_jump ? 2'd2 : id_branch_taken ? 2'd1 : 2'd0;
`ifdef BRANCH_FLUSH_EN
        fl   = (pcs != 0);
`else
        fl   = 1'b0;
`endif
        exp_mds = clrn && !busy && !lu && id_is_md;
        chk("stall",    {1'b0, stall},       {1'b0, st});
        chk("bubble",   {1'b0, bubble_idex}, {1'b0, st});
        chk("pcsource", pcsource,            pcs);
        chk("flush",    {1'b0, flush_ifid},  {1'b0, fl});
        chk("md_start", {1'b0, md_start},    {1'b0, exp_mds});
        chk("md_busy",  {1'b0, md_busy},     {1'b0, clrn && busy});
        chk("fwd_a",    fwd_a, clrn ? ref_fwd(id_rs, id_use_rs) : 2'd0);
        chk("fwd_b",    fwd_b, clrn ? ref_fwd(id_rt, id_use_rt) : 2'd0);
    endtask

    task automatic check_now();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!clrn)        hold = 0;
        else if (exp_mds) hold = MD_LAT - 1;
        else if (hold > 0) hold--;
        #1;
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rn, mem_rn} = '0;
        {id_use_rs, id_use_rt, id_branch_taken, id_jump, id_is_md} = '0;
        {ex_wreg, ex_m2reg, mem_wreg, mem_m2reg} = '0;
    endtask

    initial begin
        // Reset with active-looking inputs: every output must still be zero.
        clrn = 1'b0;
        clear_inputs();
        id_jump = 1; id_is_md = 1; id_rs = 7; id_use_rs = 1;
        mem_wreg = 1; mem_rn = 7;
        check_now();
        chk("rst_pcsource", pcsource, 2'd0);
        chk("rst_fwd_a", fwd_a, 2'd0);
        chk("rst_md_start", {1'b0, md_start}, 2'd0);
        adv();
        clear_inputs();
        clrn = 1'b1;
        check_now(); adv();

        // Load-use: one-cycle stall, then MEM load data forwarded.
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 5; id_rs = 5; id_use_rs = 1;
        check_now();
        chk("lu_stall", {1'b0, stall}, 2'd1);
        chk("lu_bubble", {1'b0, bubble_idex}, 2'd1);
        adv();
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
        mem_wreg = 1; mem_m2reg = 1; mem_rn = 5;
        check_now();
        chk("lu_fwd_a", fwd_a, 2'd3);
        chk("lu_released", {1'b0, stall}, 2'd0);
        adv();

        // EX beats MEM; EX destination 0 falls through to MEM.
        clear_inputs();
        ex_wreg = 1; ex_rn = 3; mem_wreg = 1; mem_rn = 3;
        id_rs = 3; id_rt = 3; id_use_rs = 1; id_use_rt = 1;
        check_now();
        chk("prio_a", fwd_a, 2'd1);
        chk("prio_b", fwd_b, 2'd1);
        adv();
        ex_rn = 0;
        check_now();
        chk("mem_a", fwd_a, 2'd2);
        chk("mem_b", fwd_b, 2'd2);
        adv();

        // Mul/div issue, back-to-back second issue held through BUSY.
        clear_inputs();
        id_is_md = 1;
        check_now();
        chk("md_pulse", {1'b0, md_start}, 2'd1);
        adv();
        for (int i = 0; i < MD_LAT - 1; i++) begin
            check_now();
            chk("md_hold", {1'b0, stall}, 2'd1);
            chk("md_nostart", {1'b0, md_start}, 2'd0);
            adv();
        end
        check_now();
        chk("md_reissue", {1'b0, md_start}, 2'd1);
        adv();
        id_is_md = 0;
        for (int i = 0; i < MD_LAT; i++) begin
            check_now(); adv();
        end

        // Jump beats branch.
        id_jump = 1; id_branch_taken = 1;
        check_now();
        chk("jump_pcs", pcsource, 2'd2);
`ifdef BRANCH_FLUSH_EN
        chk("jump_flush", {1'b0, flush_ifid}, 2'd1);
`else
        chk("jump_flush", {1'b0, flush_ifid}, 2'd0);
`endif
        adv();

        // Branch suppressed during load-use, taken on the following cycle.
        clear_inputs();
        id_branch_taken = 1;
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 9; id_rt = 9; id_use_rt = 1;
        check_now();
        chk("br_stall_pcs", pcsource, 2'd0);
        chk("br_stall_flush", {1'b0, flush_ifid}, 2'd0);
        adv();
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
        mem_wreg = 1; mem_m2reg = 1; mem_rn = 9;
        check_now();
        chk("br_after_pcs", pcsource, 2'd1);
        adv();

        // Reset in the second BUSY cycle aborts the count.
        clear_inputs();
        id_is_md = 1;
        check_now(); adv();
        id_is_md = 0;
        check_now(); adv();
        #2 clrn = 1'b0;
        hold = 0;
        #1;
        model_check();
        chk("abort_stall", {1'b0, stall}, 2'd0);
        chk("abort_busy", {1'b0, md_busy}, 2'd0);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        model_check();
        chk("post_rst_stall", {1'b0, stall}, 2'd0);
        chk("post_rst_start", {1'b0, md_start}, 2'd0);
        adv();
        check_now(); adv();

        // Randomized traffic on a small register window to provoke matches.
        for (int n = 0; n < 400; n++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rn           = 5'($urandom_range(0, 3));
            mem_rn          = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            id_branch_taken = 1'($urandom);
            id_jump         = ($urandom_range(0, 3) == 0);
            id_is_md        = ($urandom_range(0, 5) == 0);
            ex_wreg         = 1'($urandom);
            ex_m2reg        = 1'($urandom);
            mem_wreg        = 1'($urandom);
            mem_m2reg       = 1'($urandom);
            clrn            = ($urandom_range(0, 49) != 0);
            check_now();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the fetch stage's `stall` and `pcsource` inputs and the IF/ID flush and ID/EX bubble controls, and it selects operand forwarding for EX. It also holds issue for the full occupancy of the multi-cycle mul/div unit. It sits beside the ID stage and takes register indices and control bits from the ID, EX and MEM pipeline registers.

## Interface
- `MD_LAT`, default 4: cycles a mul/div instruction occupies EX. Legal range is 2–16.
- `clk` in 1: pipeline clock, rising edge.
- `clrn` in 1: asynchronous active-low reset.
- `id_rs`, `id_rt` in 5 each: source register indices of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1 each: the ID instruction reads `rs` / `rt`.
- `id_branch_taken` in 1: branch in ID resolved taken.
- `id_jump` in 1: jump in ID.
- `id_is_md` in 1: the ID instruction is a mul/div.
- `ex_wreg`, `ex_m2reg` in 1 each: EX instruction writes a register / is a load.
- `ex_rn` in 5: EX destination register.
- `mem_wreg`, `mem_m2reg` in 1 each: MEM instruction writes a register / is a load.
- `mem_rn` in 5: MEM destination register.
- `stall` out 1: holds the PC and IF/ID.
- `pcsource` out 2: 00 = pc+4, 01 = branch target, 10 = jump target.
- `flush_ifid` out 1: zeroes the IF/ID instruction.
- `bubble_idex` out 1: injects a NOP into ID/EX.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 00 = register file, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
- `md_start` out 1: one-cycle pulse that launches the mul/div unit.
- `md_busy` out 1: the FSM is in BUSY.

## Operation
- The FSM has two states, IDLE and BUSY. It has a 4-bit down-counter `cnt`.
- Forwarding is combinational. It is evaluated separately for rs→`fwd_a` and rt→`fwd_b`.
- A register index equal to 0 never matches anything.
- Forwarding priority, first match wins:
  - EX match with `ex_wreg` and no `ex_m2reg` → 01.
  - Else MEM match with `mem_wreg` and no `mem_m2reg` → 10.
  - Else MEM match with `mem_wreg` and `mem_m2reg` → 11.
  - Else 00.
  - A source whose `id_use_*` is 0 selects 00.
- Load-use hazard: `ex_wreg & ex_m2reg & ex_rn != 0`, and `ex_rn` matches a used source. The response is `stall = 1` and `bubble_idex = 1` for one cycle. The next cycle sees the load in MEM and forwards with select 11.
- MD issue: `id_is_md` in IDLE with no load-use stall gives:
  - `md_start = 1` in that cycle.
  - Next edge: state → BUSY, `cnt` ← `MD_LAT`−1.
- In BUSY:
  - `stall = 1`, `bubble_idex = 1`, `md_busy = 1`.
  - `cnt` decrements each edge.
  - When `cnt == 1`, the next edge returns the FSM to IDLE.
  - Total issue-hold is `MD_LAT`−1 cycles.
- Redirect when `stall = 0`:
  - `id_jump` → `pcsource` 10.
  - Else `id_branch_taken` → 01.
  - Else 00.
  - Jump has priority over branch.
- Whenever `stall = 1`: `pcsource` is forced to 00 and `flush_ifid` to 0. The branch stays in ID and is re-resolved after the stall.
- `id_is_md` arriving during BUSY is ignored. That instruction is held in ID by the stall and issues in the first IDLE cycle.

## Timing
- All outputs are combinational from the inputs and the FSM state, so there is zero-cycle latency to the stage registers.
- Reset: while `clrn` = 0, the state is IDLE, `cnt` = 0, and every output is 0 (`pcsource` 00, `fwd_*` 00). Release takes effect at the first rising edge after `clrn` goes high.
- Reset during BUSY aborts the count immediately. `md_start` is not re-issued.
- A load-use stall and a BUSY stall never coexist, because MD issue is blocked while a load-use stall is active.

## Configuration
- `BRANCH_FLUSH_EN` defined: `flush_ifid = 1` in any cycle where `stall = 0` and `pcsource != 00`. This discards the wrong-path fetch, so a taken branch or jump costs one cycle.
- `BRANCH_FLUSH_EN` undefined: `flush_ifid` is tied to 0. The instruction after a branch or jump executes as a delay slot.

## Test plan
- EX `lw` to $5 (`ex_wreg` = `ex_m2reg` = 1, `ex_rn` = 5), ID uses rs = 5 → `stall` = 1 and `bubble_idex` = 1 for exactly 1 cycle. The next cycle, with the load now in MEM, gives `fwd_a` = 11 and `stall` = 0.
- EX ALU writes $3 and MEM ALU writes $3; ID rs = rt = 3 → `fwd_a` = `fwd_b` = 01. The same case with `ex_rn` = 0 → both = 10.
- `id_is_md` with `MD_LAT` = 4 → `md_start` pulses 1 cycle, then `stall` = 1 for 3 cycles, then IDLE. A second `id_is_md` held during BUSY issues on the first IDLE cycle.
- `id_jump` and `id_branch_taken` both 1, no stall → `pcsource` = 10. With `BRANCH_FLUSH_EN`, `flush_ifid` = 1; without it, `flush_ifid` = 0.
- `id_branch_taken` = 1 during a load-use stall → `pcsource` = 00 and `flush_ifid` = 0. The next cycle gives `pcsource` = 01.
- Drop `clrn` in the second BUSY cycle → all outputs are 0 immediately. After release, `stall` = 0 with no `md_start`.
